// File: rtl/cnn_pkg.sv
// Shared types for the CNN output-tile datapath: feature-map element type,
// tile-buffer FSM states and a counter-width helper.
package cnn_pkg;

  typedef shortreal fm_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } tile_state_e;

  // Bits needed to count over range_v values, never fewer than one.
  function automatic int unsigned cnt_width(input int unsigned range_v);
    return (range_v > 32'd1) ? $clog2(range_v) : 32'd1;
  endfunction

endpackage

// File: rtl/tile_pixel_counter.sv
// Wrap counter with enable and a run-time last value; wrap is high while the
// count sits on its last value, so the next enabled cycle returns it to zero.
module tile_pixel_counter #(
  parameter int unsigned width_p = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               en,
  input  logic [width_p-1:0] last,
  output logic [width_p-1:0] count,
  output logic               wrap
);

  assign wrap = (count == last);

  // Count register: clear has priority, then enabled increment or wrap.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + width_p'(1);
    end
  end

endmodule

// File: rtl/output_tile_buffer.sv
// Output tile buffer: accumulates partial sums for one output tile over a
// number of input-channel tiles, then drains finished pixels with valid/ready.
module output_tile_buffer
  import cnn_pkg::*;
#(
  parameter int unsigned Tm_p           = 1,
  parameter int unsigned Tr_p           = 2,
  parameter int unsigned Tc_p           = 2,
  parameter int unsigned Tn_cnt_width_p = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  input  logic [Tn_cnt_width_p-1:0] num_in_tiles_i,
  output logic                      ready_o,
  input  logic                      acc_v_i,
  output fm_t                       fm_init_o [Tm_p],
  input  fm_t                       fm_i [Tm_p],
  output logic                      out_v_o,
  input  logic                      out_ready_i,
  output fm_t                       out_data_o [Tm_p],
  output logic                      done_o
);

  localparam int unsigned npix_lp  = Tr_p * Tc_p;
  localparam int unsigned pix_w_lp = cnt_width(npix_lp);

  tile_state_e state;
  tile_state_e state_next;

  logic [Tn_cnt_width_p-1:0] tile_last;
  logic [Tn_cnt_width_p-1:0] tile_cnt;
  logic [pix_w_lp-1:0]       pix_cnt;
  logic                      pix_wrap;
  logic                      tile_wrap;
  logic                      pix_en;
  logic                      tile_en;
  logic                      cnt_clear;
  logic                      wr_en;

  fm_t tile_mem [Tm_p][npix_lp];

  tile_pixel_counter #(.width_p(pix_w_lp)) u_pix_cnt (
    .clk   (clk_i),
    .reset (reset_i),
    .clear (cnt_clear),
    .en    (pix_en),
    .last  (pix_w_lp'(npix_lp - 1)),
    .count (pix_cnt),
    .wrap  (pix_wrap)
  );

  tile_pixel_counter #(.width_p(Tn_cnt_width_p)) u_tile_cnt (
    .clk   (clk_i),
    .reset (reset_i),
    .clear (cnt_clear),
    .en    (tile_en),
    .last  (tile_last),
    .count (tile_cnt),
    .wrap  (tile_wrap)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Tile total is stored as its last index; a request for 0 tiles runs one.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tile_last <= '0;
    end else if ((state == IDLE) && start_i) begin
      tile_last <= (num_in_tiles_i == '0) ? '0 : num_in_tiles_i - Tn_cnt_width_p'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en && !reset_i) begin
      for (int m = 0; m < Tm_p; m++) begin
        tile_mem[m][pix_cnt] <= fm_i[m];
      end
    end
  end

  always_comb begin
    state_next = state;
    ready_o    = 1'b0;
    out_v_o    = 1'b0;
    done_o     = 1'b0;
    pix_en     = 1'b0;
    tile_en    = 1'b0;
    cnt_clear  = 1'b0;
    wr_en      = 1'b0;
    case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (start_i) begin
          cnt_clear  = 1'b1;
          state_next = ACCUM;
        end else begin
          state_next = IDLE;
        end
      end
      ACCUM: begin
        if (acc_v_i) begin
          wr_en   = 1'b1;
          pix_en  = 1'b1;
          tile_en = pix_wrap;
          if (pix_wrap && tile_wrap) begin
            state_next = DRAIN;
          end else begin
            state_next = ACCUM;
          end
        end else begin
          state_next = ACCUM;
        end
      end
      DRAIN: begin
        out_v_o = 1'b1;
        if (out_ready_i) begin
          pix_en = 1'b1;
          if (pix_wrap) begin
            done_o     = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = DRAIN;
          end
        end else begin
          state_next = DRAIN;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The first input tile starts from zero rather than stale buffer contents.
  always_comb begin
    for (int m = 0; m < Tm_p; m++) begin
      fm_init_o[m]  = 0.0;
      out_data_o[m] = 0.0;
      if ((state == ACCUM) && (tile_cnt != '0)) begin
        fm_init_o[m] = tile_mem[m][pix_cnt];
      end else begin
        fm_init_o[m] = 0.0;
      end
      if (state == DRAIN) begin
        out_data_o[m] = tile_mem[m][pix_cnt];
      end else begin
        out_data_o[m] = 0.0;
      end
    end
  end

endmodule

// File: tb/tb_output_tile_buffer.sv
// Self-checking bench for output_tile_buffer (2 maps, 2x2 tile): table-driven
// jobs, hand-written corner sequences and randomized jobs against a reference model.
module tb_output_tile_buffer;
  import cnn_pkg::*;

  logic       clk_i;
  logic       reset_i;
  logic       start_i;
  logic [7:0] num_in_tiles_i;
  logic       ready_o;
  logic       acc_v_i;
  fm_t        fm_init_o [2];
  fm_t        fm_i [2];
  logic       out_v_o;
  logic       out_ready_i;
  fm_t        out_data_o [2];
  logic       done_o;

  int total = 0;
  int bad   = 0;

  // Reference: the buffer holds the last value written per (map, pixel).
  real mdl [2][4];
  real expd [2][4];

  typedef struct {
    logic [7:0] num;
    real        add;
    real        exp_val;
    int         stall;
  } vec_t;
  vec_t vecs [5];

  output_tile_buffer #(
    .Tm_p(2), .Tr_p(2), .Tc_p(2), .Tn_cnt_width_p(8)
  ) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .start_i        (start_i),
    .num_in_tiles_i (num_in_tiles_i),
    .ready_o        (ready_o),
    .acc_v_i        (acc_v_i),
    .fm_init_o      (fm_init_o),
    .fm_i           (fm_i),
    .out_v_o        (out_v_o),
    .out_ready_i    (out_ready_i),
    .out_data_o     (out_data_o),
    .done_o         (done_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_real(input string name, input real act, input real exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %f expected %f at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // stall: 0 always ready, 1 random ready, 2 three idle cycles before beat 2.
  task automatic drain(input int stall);
    int   p      = 0;
    int   cyc    = 0;
    int   stalls = 0;
    logic rdy;
    while (p < 4 && cyc < 100) begin
      if (stall == 0) rdy = 1'b1;
      else if (stall == 1) rdy = 1'($urandom_range(0, 1));
      else rdy = !(p == 1 && stalls < 3);
      if (stall == 2 && p == 1 && !rdy) stalls++;
      out_ready_i = rdy;
      #1;
      chk_bit("drain_valid", out_v_o, 1'b1);
      chk_real("drain_map0", out_data_o[0], expd[0][p]);
      chk_real("drain_map1", out_data_o[1], expd[1][p]);
      chk_bit("drain_done", done_o, rdy && (p == 3));
      if (rdy) p++;
      @(negedge clk_i);
      cyc++;
    end
    out_ready_i = 1'b0;
    chk_int("drain_beats", p, 4);
    #1;
    chk_bit("post_drain_ready", ready_o, 1'b1);
    chk_bit("post_drain_valid", out_v_o, 1'b0);
    chk_bit("post_drain_done", done_o, 1'b0);
  endtask

  task automatic start_job(input logic [7:0] num);
    start_i = 1'b1;
    num_in_tiles_i = num;
    #1;
    chk_bit("start_ready", ready_o, 1'b1);
    @(negedge clk_i);
    start_i = 1'b0;
    num_in_tiles_i = 8'($urandom);
    #1;
    chk_bit("accum_not_ready", ready_o, 1'b0);
  endtask

  // kind: 0 output = init + add, 1 random values with gaps, 2 fixed ramp.
  task automatic feed_pixel(input int t, input int px, input int kind, input real add);
    real ei [2];
    real v [2];
    for (int m = 0; m < 2; m++) begin
      ei[m] = (t == 0) ? 0.0 : mdl[m][px];
      if (kind == 0) v[m] = ei[m] + add;
      else if (kind == 2) v[m] = (m == 0) ? real'(px + 1) : -real'(px + 1);
      else v[m] = real'(int'($urandom_range(0, 64)) - 32) / 4.0;
    end
    acc_v_i = 1'b1;
    fm_i[0] = v[0];
    fm_i[1] = v[1];
    #1;
    chk_real("fm_init_map0", fm_init_o[0], ei[0]);
    chk_real("fm_init_map1", fm_init_o[1], ei[1]);
    chk_bit("accum_no_valid", out_v_o, 1'b0);
    @(negedge clk_i);
    acc_v_i = 1'b0;
    mdl[0][px] = v[0];
    mdl[1][px] = v[1];
  endtask

  task automatic run_job(input logic [7:0] num, input int kind, input real add,
                         input int stall, input logic use_tab, input real tab_val,
                         input logic do_drain);
    int n;
    n = (num == 8'd0) ? 1 : int'(num);
    start_job(num);
    for (int t = 0; t < n; t++) begin
      for (int px = 0; px < 4; px++) begin
        if (kind == 1 && $urandom_range(0, 3) == 0) begin
          start_i = 1'b1;
          num_in_tiles_i = 8'($urandom);
          #1;
          chk_bit("accum_gap_ready", ready_o, 1'b0);
          @(negedge clk_i);
          start_i = 1'b0;
        end
        feed_pixel(t, px, kind, add);
      end
    end
    for (int m = 0; m < 2; m++) begin
      for (int px = 0; px < 4; px++) begin
        expd[m][px] = use_tab ? tab_val : mdl[m][px];
      end
    end
    if (do_drain) drain(stall);
  endtask

  initial begin
    vecs[0] = '{num: 8'd1, add:  1.0, exp_val:  1.0, stall: 0};
    vecs[1] = '{num: 8'd3, add:  1.0, exp_val:  3.0, stall: 1};
    vecs[2] = '{num: 8'd0, add:  2.0, exp_val:  2.0, stall: 0};
    vecs[3] = '{num: 8'd2, add: -1.5, exp_val: -3.0, stall: 1};
    vecs[4] = '{num: 8'd4, add:  0.5, exp_val:  2.0, stall: 1};

    reset_i = 1'b1;
    start_i = 1'b0;
    num_in_tiles_i = 8'd0;
    acc_v_i = 1'b0;
    out_ready_i = 1'b0;
    fm_i[0] = 0.0;
    fm_i[1] = 0.0;
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    #1;
    chk_bit("reset_ready", ready_o, 1'b1);
    chk_bit("reset_valid", out_v_o, 1'b0);
    chk_bit("reset_done", done_o, 1'b0);
    chk_real("reset_init0", fm_init_o[0], 0.0);
    chk_real("reset_init1", fm_init_o[1], 0.0);
    @(negedge clk_i);

    // Single tile with the fixed ramp.
    run_job(8'd1, 2, 0.0, 0, 1'b0, 0.0, 1'b1);
    @(negedge clk_i);

    // Table-driven accumulate-by-constant jobs.
    for (int i = 0; i < 5; i++) begin
      run_job(vecs[i].num, 0, vecs[i].add, vecs[i].stall, 1'b1, vecs[i].exp_val, 1'b1);
      @(negedge clk_i);
    end

    // Backpressure: three stalled cycles before beat 2.
    run_job(8'd1, 1, 0.0, 2, 1'b0, 0.0, 1'b1);
    @(negedge clk_i);

    // Reset after two writes abandons the tile.
    start_job(8'd1);
    feed_pixel(0, 0, 1, 0.0);
    feed_pixel(0, 1, 1, 0.0);
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    #1;
    chk_bit("rst_accum_ready", ready_o, 1'b1);
    chk_bit("rst_accum_valid", out_v_o, 1'b0);
    @(negedge clk_i);
    run_job(8'd1, 2, 0.0, 0, 1'b0, 0.0, 1'b1);
    @(negedge clk_i);

    // acc_v_i in IDLE must neither write nor move the pixel counter.
    acc_v_i = 1'b1;
    fm_i[0] = 99.0;
    fm_i[1] = 99.0;
    #1;
    chk_bit("idle_acc_ready", ready_o, 1'b1);
    chk_real("idle_acc_init", fm_init_o[0], 0.0);
    @(negedge clk_i);
    @(negedge clk_i);
    acc_v_i = 1'b0;
    run_job(8'd2, 0, 1.0, 0, 1'b1, 2.0, 1'b1);
    @(negedge clk_i);

    // Simultaneous reset and start stays in IDLE.
    reset_i = 1'b1;
    start_i = 1'b1;
    num_in_tiles_i = 8'd1;
    @(negedge clk_i);
    reset_i = 1'b0;
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_bit("rst_start_ready", ready_o, 1'b1);
      chk_bit("rst_start_valid", out_v_o, 1'b0);
      @(negedge clk_i);
    end

    // Reset in the middle of a drain: no further valid beats.
    run_job(8'd1, 1, 0.0, 0, 1'b0, 0.0, 1'b0);
    out_ready_i = 1'b1;
    #1;
    chk_bit("mid_drain_valid", out_v_o, 1'b1);
    chk_real("mid_drain_data", out_data_o[0], expd[0][0]);
    @(negedge clk_i);
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_bit("rst_drain_valid", out_v_o, 1'b0);
      chk_bit("rst_drain_ready", ready_o, 1'b1);
      @(negedge clk_i);
    end
    out_ready_i = 1'b0;

    // Randomized jobs with gaps, ignored starts and random backpressure.
    for (int j = 0; j < 8; j++) begin
      run_job(8'($urandom_range(0, 3)), 1, 0.0, 1, 1'b0, 0.0, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/output_tile_buffer.md
OUTPUT_TILE_BUFFER -- requirements
Module: output_tile_buffer

Interface
REQ-001 Parameters SHALL be: Tm_p, default 1, output maps per tile; Tr_p, default 2, tile rows; Tc_p, default 2, tile columns; Tn_cnt_width_p, default 8, input-tile count width.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset, with ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- start_i  in  1  begin a new output tile; accepted only in IDLE
- num_in_tiles_i  in  Tn_cnt_width_p  input-channel tiles to accumulate; sampled on accepted start_i
- ready_o  out  1  high in IDLE only
- acc_v_i  in  1  compute stage result for the current pixel is valid
- fm_init_o  out  shortreal [Tm_p]  partial sums driven into the compute stage's init inputs
- fm_i  in  shortreal [Tm_p]  compute stage outputs for the current pixel
- out_v_o  out  1  drain data valid
- out_ready_i  in  1  downstream accepts drain data
- out_data_o  out  shortreal [Tm_p]  one finished pixel, all Tm_p maps
- done_o  out  1  single-cycle pulse on final drain handshake

Function
REQ-003 The block SHALL hold Tm_p x (Tr_p*Tc_p) shortreal partial sums in a register array.
REQ-004 The FSM SHALL have exactly three states: IDLE, ACCUM, DRAIN.
REQ-005 IDLE->ACCUM SHALL occur on start_i; the pixel counter and tile counter SHALL be cleared, and the tile total SHALL be latched, with 0 treated as 1.
REQ-006 In ACCUM, fm_init_o SHALL be combinational, with no register between address and output:
- 0.0 for every map while the tile counter is 0
- otherwise the stored value at the current pixel.
REQ-007 In ACCUM, each acc_v_i cycle SHALL write fm_i to the current pixel and advance the pixel counter in row-major order (c fastest).
REQ-008 Pixel counter wrap-around from Tr_p*Tc_p-1 to 0 SHALL increment the tile counter.
REQ-009 A write to the last pixel of the last tile SHALL move the FSM to DRAIN on the next cycle, with the pixel counter reset to 0.
REQ-010 acc_v_i SHALL be ignored outside ACCUM, and fm_init_o SHALL be 0.0 outside ACCUM.
REQ-011 In DRAIN, out_v_o SHALL be high and out_data_o SHALL show the stored pixel at the pixel counter.
- The first valid beat appears the cycle after the final ACCUM write.
- Each out_v_o&&out_ready_i handshake advances one pixel.
REQ-012 While out_ready_i is low, out_data_o SHALL stay stable and the counter SHALL hold, so no pixel is skipped or duplicated.
REQ-013 The handshake on the last pixel SHALL pulse done_o for that cycle and return the FSM to IDLE on the next cycle.
REQ-014 start_i SHALL be ignored in ACCUM and DRAIN, and num_in_tiles_i SHALL be ignored except on an accepted start.
REQ-015 Counter widths SHALL be $clog2 of their ranges, with a minimum of 1 bit.

Reset
REQ-016 On reset_i, the FSM SHALL enter IDLE and all counters SHALL clear.
- Outputs: ready_o=1, out_v_o=0, done_o=0, fm_init_o=0.0.
REQ-017 Buffer contents SHALL NOT be cleared on reset and are don't-care until overwritten by tile 0.
REQ-018 Reset mid-ACCUM or mid-DRAIN SHALL abandon the tile with no further out_v_o.

Structure
REQ-019 The shared package cnn_pkg SHALL hold:
- the feature-map datatype typedef, shortreal
- the FSM state enum.
REQ-020 The buffer SHALL use one sub-module, tile_pixel_counter, a parameterized wrap counter with enable and wrap flag, instanced for the pixel and tile counts.

Verification (Tm_p=2, Tr_p=2, Tc_p=2)
REQ-021 Single tile: start, num=1, feed pixels map0=1.0,2.0,3.0,4.0 and map1=-1.0..-4.0 -> fm_init_o=0.0 every beat; drain returns exactly those 4 pixels in order; done_o pulses once.
REQ-022 Three tiles: each compute output = fm_init+1.0 per map -> tile 1 sees fm_init 1.0, tile 2 sees 2.0; drain gives 3.0 for all 8 values.
REQ-023 Backpressure: out_ready_i low for 3 cycles after drain beat 1 -> beat 2 data stable throughout; 4 beats total; done_o on beat 4 only.
REQ-024 Reset after 2 ACCUM writes -> next cycle ready_o=1 and out_v_o=0; a new num=1 run reproduces REQ-021 results.
REQ-025 Illegal and edge inputs:
- start_i pulsed in ACCUM -> no effect.
- acc_v_i in IDLE -> no write.
- num=0 -> behaves as num=1.
- Simultaneous reset_i and start_i -> stays IDLE.
